// File: rtl/aes_round_engine.sv
// Iterative AES block engine: one encrypt or decrypt round per clock, round keys fetched by index.
// Optional macro AES_BACKTOBACK_EN: the output handshake edge may also accept the next block.
module aes_round_engine #(
    parameter int KEY_BITS = 128,
    parameter int TAG_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_decrypt,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [127:0]     i_block,
    output logic [3:0]       o_rk_idx,
    input  logic [127:0]     i_rk,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [127:0]     o_block,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy,
    output logic [3:0]       o_round
);
    localparam int NR = (KEY_BITS == 256) ? 14 : (KEY_BITS == 192) ? 12 : 10;
    localparam logic [3:0] NR4 = 4'(NR);
`ifdef AES_BACKTOBACK_EN
    localparam bit BACK2BACK = 1'b1;
`else
    localparam bit BACK2BACK = 1'b0;
`endif

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
            $error("aes_round_engine: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Inverse in GF(2^8) as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] acc;
        logic [7:0] base;
        acc  = 8'h01;
        base = a;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            acc  = gf_mul(acc, base);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    // One column, row 0 in the top byte.
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0]  a [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (inv)
                r[31-8*i -: 8] = gf_mul(a[i], 8'h0e) ^ gf_mul(a[(i+1)%4], 8'h0b)
                               ^ gf_mul(a[(i+2)%4], 8'h0d) ^ gf_mul(a[(i+3)%4], 8'h09);
            else
                r[31-8*i -: 8] = xtime(a[i]) ^ xtime(a[(i+1)%4]) ^ a[(i+1)%4]
                               ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
        return r;
    endfunction

    fsm_t             fsm_q, fsm_d;
    logic [127:0]     state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic             dec_q, dec_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             valid_q, valid_d;
    logic [127:0]     oblk_q, oblk_d;
    logic [TAG_W-1:0] otag_q, otag_d;

    logic [7:0]   st_b [16];
    logic [127:0] sub_v, isub_v, mix_v, ark_v, imix_v, round_out;
    logic         last_round;
    logic         accept;

    // Byte gi sits at column gi/4, row gi%4; shifts are folded into the S-box input selection.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            assign st_b[gi]               = state_q[127-8*gi -: 8];
            assign sub_v[127-8*gi -: 8]   = sbox(st_b[4*((COL+ROW)%4)+ROW]);
            assign isub_v[127-8*gi -: 8]  = inv_sbox(st_b[4*((COL+4-ROW)%4)+ROW]);
        end
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign mix_v[127-32*gi -: 32]  = mix_col(sub_v[127-32*gi -: 32], 1'b0);
            assign imix_v[127-32*gi -: 32] = mix_col(ark_v[127-32*gi -: 32], 1'b1);
        end
    endgenerate

    assign ark_v      = isub_v ^ i_rk;
    assign last_round = (round_q == NR4);
    assign round_out  = dec_q ? (last_round ? ark_v : imix_v)
                              : ((last_round ? sub_v : mix_v) ^ i_rk);

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        round_d  = round_q;
        dec_d    = dec_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
        oblk_d   = oblk_q;
        otag_d   = otag_q;
        o_ready  = 1'b0;
        o_rk_idx = i_decrypt ? NR4 : 4'd0;
        accept   = 1'b0;
        case (fsm_q)
            IDLE: begin
                o_ready = 1'b1;
                accept  = i_valid;
            end
            RUN: begin
                o_rk_idx = dec_q ? (NR4 - round_q) : round_q;
                if (last_round) begin
                    oblk_d  = round_out;
                    otag_d  = tag_q;
                    valid_d = 1'b1;
                    round_d = 4'd0;
                    fsm_d   = DONE;
                end else begin
                    state_d = round_out;
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                o_ready = BACK2BACK & i_ready;
                if (i_ready) begin
                    valid_d = 1'b0;
                    fsm_d   = IDLE;
                    accept  = BACK2BACK & i_valid;
                end
            end
            default: fsm_d = IDLE;
        endcase
        // o_rk_idx already points at the new block's first key when accepting.
        if (accept) begin
            state_d = i_block ^ i_rk;
            dec_d   = i_decrypt;
            tag_d   = i_tag;
            round_d = 4'd1;
            fsm_d   = RUN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            oblk_q  <= '0;
            otag_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            oblk_q  <= oblk_d;
            otag_q  <= otag_d;
        end
    end

    assign o_valid = valid_q;
    assign o_block = oblk_q;
    assign o_tag   = otag_q;
    assign o_busy  = (fsm_q == RUN);
    assign o_round = round_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: a 128-bit and a 256-bit instance driven from one directed sequence,
// checked against known answers and a byte-level AES model with its own key schedule.
module tb_aes_round_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a    [2];
    logic         valid_a  [2];
    logic         dec_a    [2];
    logic [3:0]   tag_a    [2];
    logic [127:0] blk_a    [2];
    logic         iready_a [2];
    logic         rdy_a    [2];
    logic [3:0]   idx_a    [2];
    logic [127:0] rk_a     [2];
    logic         vout_a   [2];
    logic [127:0] oblk_a   [2];
    logic [3:0]   otag_a   [2];
    logic         busy_a   [2];
    logic [3:0]   round_a  [2];

    logic [127:0] rk_mem [2][15];
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int oor = 0;
    logic [3:0]   rk_log [$];
    int           hs_cyc [$];
    logic [3:0]   hs_tag [$];
    logic [127:0] hs_blk [$];

    assign rk_a[0] = rk_mem[0][idx_a[0]];
    assign rk_a[1] = rk_mem[1][idx_a[1]];

    aes_round_engine #(.KEY_BITS(128), .TAG_W(4)) dut128 (
        .i_clk(clk), .i_rst(rst_a[0]), .i_valid(valid_a[0]), .o_ready(rdy_a[0]),
        .i_decrypt(dec_a[0]), .i_tag(tag_a[0]), .i_block(blk_a[0]), .o_rk_idx(idx_a[0]),
        .i_rk(rk_a[0]), .o_valid(vout_a[0]), .i_ready(iready_a[0]), .o_block(oblk_a[0]),
        .o_tag(otag_a[0]), .o_busy(busy_a[0]), .o_round(round_a[0]));

    aes_round_engine #(.KEY_BITS(256), .TAG_W(4)) dut256 (
        .i_clk(clk), .i_rst(rst_a[1]), .i_valid(valid_a[1]), .o_ready(rdy_a[1]),
        .i_decrypt(dec_a[1]), .i_tag(tag_a[1]), .i_block(blk_a[1]), .o_rk_idx(idx_a[1]),
        .i_rk(rk_a[1]), .o_valid(vout_a[1]), .i_ready(iready_a[1]), .o_block(oblk_a[1]),
        .o_tag(otag_a[1]), .o_busy(busy_a[1]), .o_round(round_a[1]));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (idx_a[0] > 4'd10 || idx_a[1] > 4'd14) oor++;
        if (vout_a[0] && iready_a[0]) begin
            hs_cyc.push_back(cyc);
            hs_tag.push_back(otag_a[0]);
            hs_blk.push_back(oblk_a[0]);
        end
    end

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box by walking generator 3 and its inverse in lockstep.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand(input int sel, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk_mem[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_cipher(input logic [127:0] blk, input logic dec, input int sel);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [7:0]   cf [4];
        logic [127:0] k, res;
        int nr;
        nr = (sel == 1) ? 14 : 10;
        if (dec) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        k = rk_mem[sel][dec ? nr : 0];
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            k = rk_mem[sel][dec ? nr - rnd : rnd];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = dec ? isbox[s[4*((c+4-r)%4)+r]] : sbox[s[4*((c+r)%4)+r]];
            if (dec) for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = t[4*c+j];
                    for (int j = 0; j < 4; j++)
                        t[4*c+j] = gm(a[j], cf[0]) ^ gm(a[(j+1)%4], cf[1])
                                 ^ gm(a[(j+2)%4], cf[2]) ^ gm(a[(j+3)%4], cf[3]);
                end
            end
            if (!dec) for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
            s = t;
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Presents one block, records key indices, counts clocks to o_valid, stalls, then handshakes.
    task automatic run_block(input int sel, input logic [127:0] blk, input logic dec, input logic [3:0] tag,
                             input int stall, output logic [127:0] res, output logic [3:0] rtag,
                             output int lat);
        int n;
        logic [127:0] held;
        @(posedge clk); #1;
        valid_a[sel] = 1'b1; blk_a[sel] = blk; dec_a[sel] = dec; tag_a[sel] = tag;
        iready_a[sel] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rdy_a[sel] && n < 50) begin @(negedge clk); n++; end
        check("accept_ready", rdy_a[sel], 1);
        rk_log.delete();
        rk_log.push_back(idx_a[sel]);
        @(posedge clk); #1;
        valid_a[sel] = 1'b0; dec_a[sel] = ~dec; tag_a[sel] = 4'($urandom); blk_a[sel] = {4{$urandom}};
        lat = 0;
        while (!vout_a[sel] && lat < 40) begin
            @(negedge clk);
            if (busy_a[sel]) rk_log.push_back(idx_a[sel]);
            @(posedge clk); #1;
            lat++;
        end
        res  = oblk_a[sel];
        rtag = otag_a[sel];
        held = oblk_a[sel];
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("bp_valid", vout_a[sel], 1);
            check("bp_block", oblk_a[sel], held);
            check("bp_tag", otag_a[sel], tag);
            check("bp_ready", rdy_a[sel], 0);
        end
        @(posedge clk); #1; iready_a[sel] = 1'b1;
        @(posedge clk); #1;
        check("hs_clears_valid", vout_a[sel], 0);
        iready_a[sel] = 1'b0;
    endtask

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        logic [127:0] res, blk, b1, b2;
        logic [3:0]   rtag, tg;
        logic         dec;
        int lat, n, sel, spacing;

        build_sbox();
        expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        for (int i = 0; i < 2; i++) begin
            rst_a[i] = 1'b0; valid_a[i] = 1'b0; dec_a[i] = 1'b0; tag_a[i] = 4'h0;
            blk_a[i] = '0; iready_a[i] = 1'b0;
        end
        check("model_kat128", ref_cipher(PT, 1'b0, 0), CT128);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_valid", vout_a[i], 0);
            check("rst_busy", busy_a[i], 0);
            check("rst_round", round_a[i], 0);
            check("rst_block", oblk_a[i], 0);
            check("rst_tag", otag_a[i], 0);
        end
        rst_a[0] = 1'b1; rst_a[1] = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", rdy_a[0], 1);
        check("ready_after_rst_256", rdy_a[1], 1);

        run_block(0, PT, 1'b0, 4'h9, 0, res, rtag, lat);
        check("enc128_block", res, CT128);
        check("enc128_latency", lat, 10);
        check("enc128_tag", rtag, 4'h9);

        run_block(0, CT128, 1'b1, 4'h2, 0, res, rtag, lat);
        check("dec128_block", res, PT);
        check("dec128_tag", rtag, 4'h2);
        check("dec_rk_seq_len", rk_log.size(), 11);
        for (int i = 0; i < rk_log.size() && i < 11; i++) check("dec_rk_idx", rk_log[i], 10 - i);

        run_block(1, PT, 1'b0, 4'h6, 0, res, rtag, lat);
        check("enc256_block", res, CT256);
        check("enc256_latency", lat, 14);
        run_block(1, CT256, 1'b1, 4'h7, 0, res, rtag, lat);
        check("dec256_block", res, PT);
        check("dec256_latency", lat, 14);

        blk = {$urandom, $urandom, $urandom, $urandom};
        run_block(0, blk, 1'b0, 4'hc, 5, res, rtag, lat);
        check("bp_result", res, ref_cipher(blk, 1'b0, 0));

        for (int i = 0; i < 8; i++) begin
            sel = i % 2;
            blk = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom);
            tg  = 4'($urandom);
            run_block(sel, blk, dec, tg, 1, res, rtag, lat);
            check("rand_block", res, ref_cipher(blk, dec, sel));
            check("rand_tag", rtag, tg);
            check("rand_latency", lat, sel ? 14 : 10);
        end

        // Reset pulse while round 4 is in flight.
        @(posedge clk); #1;
        valid_a[0] = 1'b1; blk_a[0] = PT; dec_a[0] = 1'b0; tag_a[0] = 4'ha;
        @(posedge clk); #1;
        valid_a[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (round_a[0] != 4'd4 && n < 20) begin @(negedge clk); n++; end
        check("reached_round4", round_a[0], 4);
        #2 rst_a[0] = 1'b0;
        #1;
        check("midrst_busy", busy_a[0], 0);
        check("midrst_valid", vout_a[0], 0);
        check("midrst_block", oblk_a[0], 0);
        check("midrst_round", round_a[0], 0);
        @(negedge clk); rst_a[0] = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", rdy_a[0], 1);
        blk = {$urandom, $urandom, $urandom, $urandom};
        run_block(0, blk, 1'b0, 4'h4, 0, res, rtag, lat);
        check("post_rst_block", res, ref_cipher(blk, 1'b0, 0));
        check("post_rst_latency", lat, 10);

        // Two blocks with i_valid and i_ready held high.
        b1 = {$urandom, $urandom, $urandom, $urandom};
        b2 = {$urandom, $urandom, $urandom, $urandom};
        hs_cyc.delete(); hs_tag.delete(); hs_blk.delete();
        @(posedge clk); #1;
        iready_a[0] = 1'b1; valid_a[0] = 1'b1; blk_a[0] = b1; dec_a[0] = 1'b0; tag_a[0] = 4'h3;
        n = 0;
        @(negedge clk);
        while (!rdy_a[0] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        blk_a[0] = b2; tag_a[0] = 4'h5;
        n = 0;
        @(negedge clk);
        while (!rdy_a[0] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        valid_a[0] = 1'b0;
        n = 0;
        while (hs_cyc.size() < 2 && n < 60) begin @(posedge clk); #1; n++; end
        iready_a[0] = 1'b0;
`ifdef AES_BACKTOBACK_EN
        spacing = 11;
`else
        spacing = 12;
`endif
        check("b2b_handshakes", hs_cyc.size(), 2);
        if (hs_cyc.size() >= 2) begin
            check("b2b_spacing", hs_cyc[1] - hs_cyc[0], spacing);
            check("b2b_tag0", hs_tag[0], 4'h3);
            check("b2b_tag1", hs_tag[1], 4'h5);
            check("b2b_block0", hs_blk[0], ref_cipher(b1, 1'b0, 0));
            check("b2b_block1", hs_blk[1], ref_cipher(b2, 1'b0, 0));
        end

        repeat (2) @(negedge clk);
        check("rk_idx_in_range", oor, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
